sram_nbank_preload: RTL
=======================

# sram_nbank_preload

Parametrised N-bank interleaved page memory with a built-in preload engine and a registered read port. A valid/ready word stream fills the memory page by page. Words are packed into interleaved bank lanes. After preload completes, pages or single words are read with one-cycle latency. It generalises the one/two-bank LUTRAM page memories used for compression-pattern storage to arbitrary bank count, with preload sequencing and read gating.

## Interface
- QUAN_SIZE, 4, bits per word (one bank lane)
- BANK_INTERLEAVE, 2, banks per page; power of two, ≥2
- WSEL_BITWIDTH, 1, log2(BANK_INTERLEAVE)
- PAGE_NUM, 16, pages; power of two
- ADDR_BITWIDTH, 4, log2(PAGE_NUM)
- Reset is asynchronous, active-high.
- sys_clk  in  1  single clock; all logic on rising edge
- sys_rst  in  1  asynchronous active-high reset
- preload_start_i  in  1  begin or restart preload
- preload_data_i  in  QUAN_SIZE  preload word
- preload_valid_i  in  1  preload word valid
- preload_ready_o  out  1  engine accepts a word
- preload_done_o  out  1  one-cycle pulse when the final page is written
- mem_ready_o  out  1  level; memory contents valid for reads
- read_en_i  in  1  read request
- read_addr_i  in  ADDR_BITWIDTH  page address
- read_strobe_i  in  WSEL_BITWIDTH  bank/word select
- read_page_o  out  QUAN_SIZE*BANK_INTERLEAVE  registered page
- read_word_o  out  QUAN_SIZE  registered selected word
- read_valid_o  out  1  read data valid
- read_err_o  out  1  one-cycle pulse: read requested while not ready

## Operation
- Storage: PAGE_NUM × (QUAN_SIZE*BANK_INTERLEAVE) bits, distributed RAM.
  - Bank b occupies page bits [(b+1)*QUAN_SIZE-1 : b*QUAN_SIZE].
  - Memory contents are not reset.
- FSM states:
  - IDLE: reset state. preload_start_i → PRELOAD.
  - PRELOAD: accepts words. After the final word is accepted → READY. preload_start_i → restart.
  - READY: serves reads. preload_start_i → PRELOAD.
- Entering PRELOAD (from any state):
  - Clear the word counter (bank index) and page counter.
  - Clear mem_ready_o.
  - Discard any partial page assembly.
  - Pages already written remain in RAM but are treated as invalid.
- preload_ready_o = 1 only in PRELOAD; 0 in the cycle preload_start_i is sampled.
- Word packing: the k-th accepted word goes to bank (k mod BANK_INTERLEAVE) of page (k / BANK_INTERLEAVE).
  - Lanes 0..B-2 are held in a staging register.
  - The RAM write of the full page occurs on the cycle the lane B-1 word is accepted (staging plus the incoming word).
- Total preload: PAGE_NUM*BANK_INTERLEAVE accepted words.
  - Counters wrap to 0 after the last page.
  - The FSM moves to READY at that point.
- Reads:
  - Only in READY with read_en_i = 1.
  - Address and strobe are sampled.
  - read_word_o = lane read_strobe_i of the page read.
- read_en_i outside READY: no RAM access, read_valid_o = 0, read_err_o pulses.
- Read and preload_start_i in the same READY cycle: the read is served (valid next cycle); the FSM still moves to PRELOAD.

## Timing
- Reset values: preload_ready_o = 0, preload_done_o = 0, mem_ready_o = 0, read_valid_o = 0, read_err_o = 0, read_page_o = 0, read_word_o = 0, FSM = IDLE, counters = 0.
- Reset mid-preload returns the block to IDLE; re-entry requires preload_start_i.
- preload_start_i at cycle t: preload_ready_o = 1 from t+1.
- Handshake: a word transfers when preload_valid_i & preload_ready_o; at most one word per cycle. Gaps in preload_valid_i stall the counters.
- Final word accepted at cycle t:
  - Page written at the t edge.
  - At t+1: preload_done_o = 1 (one cycle), mem_ready_o = 1, preload_ready_o = 0.
- Minimum preload latency: 1 + PAGE_NUM*BANK_INTERLEAVE cycles from start to done.
- Read latency: one cycle. Request at t gives data and read_valid_o at t+1.
- read_page_o/read_word_o hold their last value while read_valid_o = 0.
- Back-to-back reads give one result per cycle.
- read_err_o is asserted at t+1 for a rejected request at t.

## Test plan
All scenarios use the default parameters.
- Reset, then idle: all outputs 0. read_en_i = 1, addr 3 → read_err_o = 1 for one cycle; read_valid_o stays 0.
- Continuous preload: words 0..31 (value = k mod 16) → done pulse exactly 33 cycles after start, mem_ready_o = 1. Read page 5, strobe 1 → next cycle read_page_o = 8'hBA, read_word_o = 4'hB, read_valid_o = 1.
- Preload with preload_valid_i toggling every other cycle → identical final contents; done at cycle 65 after start.
- Restart mid-preload: after 7 words, assert preload_start_i; preload 32 fresh words (value 4'hF) → all pages read 8'hFF; exactly one done pulse.
- Async reset asserted after 20 words → immediate IDLE, all outputs 0. A subsequent read rejected with read_err_o.
- READY: back-to-back reads at pages 0, 15, 0 with strobes 0, 1, 1 → three consecutive valid cycles with the correct words. preload_start_i concurrent with the last read → that read is valid; mem_ready_o drops the next cycle.

Source files
------------

// File: rtl/sram_nbank_preload_if.sv
// Preload stream and read port bundle for sram_nbank_preload.
// The slave modport is the memory; the master modport is whoever feeds and reads it.
interface sram_nbank_preload_if #(
  parameter int QUAN_SIZE       = 4,
  parameter int BANK_INTERLEAVE = 2,
  parameter int WSEL_BITWIDTH   = 1,
  parameter int ADDR_BITWIDTH   = 4
);
  logic                                 preload_start_i;
  logic [QUAN_SIZE-1:0]                 preload_data_i;
  logic                                 preload_valid_i;
  logic                                 preload_ready_o;
  logic                                 preload_done_o;
  logic                                 mem_ready_o;
  logic                                 read_en_i;
  logic [ADDR_BITWIDTH-1:0]             read_addr_i;
  logic [WSEL_BITWIDTH-1:0]             read_strobe_i;
  logic [QUAN_SIZE*BANK_INTERLEAVE-1:0] read_page_o;
  logic [QUAN_SIZE-1:0]                 read_word_o;
  logic                                 read_valid_o;
  logic                                 read_err_o;

  modport master (
    output preload_start_i, preload_data_i, preload_valid_i,
           read_en_i, read_addr_i, read_strobe_i,
    input  preload_ready_o, preload_done_o, mem_ready_o,
           read_page_o, read_word_o, read_valid_o, read_err_o
  );

  modport slave (
    input  preload_start_i, preload_data_i, preload_valid_i,
           read_en_i, read_addr_i, read_strobe_i,
    output preload_ready_o, preload_done_o, mem_ready_o,
           read_page_o, read_word_o, read_valid_o, read_err_o
  );
endinterface

// File: rtl/sram_nbank_preload.sv
// N-bank interleaved page memory: a word stream fills pages lane by lane,
// then pages/words are read back through a one-cycle registered port.
module sram_nbank_preload #(
  parameter int QUAN_SIZE       = 4,
  parameter int BANK_INTERLEAVE = 2,
  parameter int WSEL_BITWIDTH   = 1,
  parameter int PAGE_NUM        = 16,
  parameter int ADDR_BITWIDTH   = 4
) (
  input logic                 sys_clk,
  input logic                 sys_rst,
  sram_nbank_preload_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PRELOAD, READY} state_t;

  localparam logic [WSEL_BITWIDTH-1:0] LAST_WORD = WSEL_BITWIDTH'(BANK_INTERLEAVE-1);
  localparam logic [ADDR_BITWIDTH-1:0] LAST_PAGE = ADDR_BITWIDTH'(PAGE_NUM-1);

  state_t state, state_nxt;

  logic [WSEL_BITWIDTH-1:0]                        word_cnt;
  logic [ADDR_BITWIDTH-1:0]                        page_cnt;
  logic [BANK_INTERLEAVE-2:0][QUAN_SIZE-1:0]       staging;
  logic [BANK_INTERLEAVE-1:0][QUAN_SIZE-1:0]       mem [PAGE_NUM];
  logic [BANK_INTERLEAVE-1:0][QUAN_SIZE-1:0]       rd_lanes;
  logic [BANK_INTERLEAVE-1:0][QUAN_SIZE-1:0]       rd_page_q;
  logic [QUAN_SIZE-1:0]                            rd_word_q;
  logic ready_c, accept, page_wr, final_wr, rd_ok;
  logic done_q, rd_vld_q, rd_err_q;

  // Start has priority over the stream, so no word is taken in the start cycle.
  assign ready_c  = (state == PRELOAD) && !bus.preload_start_i;
  assign accept   = ready_c && bus.preload_valid_i;
  assign page_wr  = accept && (word_cnt == LAST_WORD);
  assign final_wr = page_wr && (page_cnt == LAST_PAGE);
  assign rd_ok    = bus.read_en_i && (state == READY);
  assign rd_lanes = mem[bus.read_addr_i];

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.preload_start_i) state_nxt = PRELOAD;
      PRELOAD: if (bus.preload_start_i) state_nxt = PRELOAD;
               else if (final_wr)       state_nxt = READY;
      READY:   if (bus.preload_start_i) state_nxt = PRELOAD;
      default:                          state_nxt = IDLE;
    endcase
  end

  // Counters restart on every start; stale staging lanes get overwritten before use.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      word_cnt <= '0;
      page_cnt <= '0;
      staging  <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= final_wr;
      if (bus.preload_start_i) begin
        word_cnt <= '0;
        page_cnt <= '0;
      end else if (accept) begin
        if (page_wr) begin
          word_cnt <= '0;
          page_cnt <= page_cnt + ADDR_BITWIDTH'(1);
        end else begin
          staging[word_cnt] <= bus.preload_data_i;
          word_cnt          <= word_cnt + WSEL_BITWIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (page_wr) mem[page_cnt] <= {bus.preload_data_i, staging};
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rd_page_q <= '0;
      rd_word_q <= '0;
      rd_vld_q  <= 1'b0;
      rd_err_q  <= 1'b0;
    end else begin
      rd_vld_q <= rd_ok;
      rd_err_q <= bus.read_en_i && (state != READY);
      if (rd_ok) begin
        rd_page_q <= rd_lanes;
        rd_word_q <= rd_lanes[bus.read_strobe_i];
      end
    end
  end

  assign bus.preload_ready_o = ready_c;
  assign bus.preload_done_o  = done_q;
  assign bus.mem_ready_o     = (state == READY);
  assign bus.read_page_o     = rd_page_q;
  assign bus.read_word_o     = rd_word_q;
  assign bus.read_valid_o    = rd_vld_q;
  assign bus.read_err_o      = rd_err_q;
endmodule
